// File: rtl/nv_nvdla_sdp_pack_pkg.sv
// Shared helpers for the SDP gather/pack block: sizing functions and ratio clamping.
package nv_nvdla_sdp_pack_pkg;

  // Ceiling log2; the result is the number of bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Map a raw ratio request onto the legal range [1..max_ratio].
  // A request of 0 means 1, and anything above the maximum saturates.
  function automatic int clamp_ratio(input int cfg, input int max_ratio);
    if (cfg <= 0) begin
      return 1;
    end
    if (cfg > max_ratio) begin
      return max_ratio;
    end
    return cfg;
  endfunction

  // Default geometry: 128-bit beats, up to 16 beats per packed word.
  localparam int DEF_IW        = 128;
  localparam int DEF_MAX_RATIO = 16;
  localparam int DEF_OW        = DEF_IW * DEF_MAX_RATIO;
  localparam int DEF_CW        = clog2(DEF_MAX_RATIO + 1);

endpackage

// File: rtl/nv_nvdla_sdp_pack_oreg.sv
// Single valid/ready holding stage. A new word may load in the same cycle the
// current one drains, so back-to-back words flow with no bubble.
module nv_nvdla_sdp_pack_oreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         pvld,
  input  logic         prdy,
  output logic [W-1:0] data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  // Load has priority over drain; payload only changes on load so it holds while stalled.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (prdy) begin
      valid_reg <= 1'b0;
    end
  end

  assign pvld = valid_reg;
  assign data = data_reg;

  // Upstream must never load over a word that is still waiting.
  a_no_overwrite: assert property (@(posedge clk) disable iff (srst)
    load |-> (!valid_reg || prdy));

endmodule

// File: rtl/nv_nvdla_sdp_core_gpack.sv
// Gathers IW-bit beats into one OW-bit packed word. Ratio is latched at the first
// beat of each group; inp_last closes a group early. The gather buffer fills the
// next group while the output register waits on out_prdy.
module nv_nvdla_sdp_core_gpack
  import nv_nvdla_sdp_pack_pkg::*;
#(
  parameter int IW        = DEF_IW,
  parameter int MAX_RATIO = DEF_MAX_RATIO,
  parameter int OW        = IW * MAX_RATIO,
  parameter int CW        = clog2(MAX_RATIO + 1)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rst,
  input  logic [CW-1:0]        cfg_ratio,
  input  logic                 inp_pvld,
  output logic                 inp_prdy,
  input  logic [IW-1:0]        inp_data,
  input  logic                 inp_last,
  output logic                 out_pvld,
  input  logic                 out_prdy,
  output logic [OW-1:0]        out_data,
  output logic [MAX_RATIO-1:0] out_mask,
  output logic                 out_last,
  output logic                 idle
);

  logic [CW-1:0]        cnt_reg;
  logic [CW-1:0]        ratio_reg;
  logic [CW-1:0]        ratio_cur;
  logic [CW-1:0]        last_idx;
  logic [MAX_RATIO-1:0] gmask;
  logic [MAX_RATIO-1:0] merged_mask;
  logic [OW-1:0]        merged_data;
  logic                 merged_last;
  logic                 close_if_acc;
  logic                 acc;
  logic                 close;

  // The first beat of a group sees the freshly clamped request; later beats use the latched one.
  assign ratio_cur    = (cnt_reg == '0) ? CW'(clamp_ratio(int'(cfg_ratio), MAX_RATIO)) : ratio_reg;
  assign last_idx     = ratio_cur - CW'(1);
  assign close_if_acc = (cnt_reg == last_idx) | inp_last;

  // Only a closing beat needs room in the output register; filling beats never stall.
  assign inp_prdy = !nvdla_core_rst & (!close_if_acc | !out_pvld | out_prdy);
  assign acc      = inp_pvld & inp_prdy;
  assign close    = acc & close_if_acc;

  // An early close that lands exactly on the final slot is an ordinary full group.
  assign merged_last = inp_last & (cnt_reg != last_idx);

  // Slot counter and per-group ratio latch.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cnt_reg   <= '0;
      ratio_reg <= CW'(1);
    end else if (acc) begin
      if (cnt_reg == '0) begin
        ratio_reg <= ratio_cur;
      end
      cnt_reg <= close ? '0 : (cnt_reg + CW'(1));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_RATIO; gi++) begin : gen_slot
      logic [IW-1:0] slot_reg;
      logic          fill_reg;
      logic          hit;

      assign hit = (cnt_reg == CW'(gi));

      // Capture the beat aimed at this slot; empty the slot when its group is handed off.
      always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || close) begin
          slot_reg <= '0;
          fill_reg <= 1'b0;
        end else if (acc && hit) begin
          slot_reg <= inp_data;
          fill_reg <= 1'b1;
        end
      end

      // Slots past the current beat are already zero because they were cleared at the last close.
      assign merged_data[gi*IW +: IW] = hit ? inp_data : slot_reg;
      assign merged_mask[gi]          = fill_reg | hit;
      assign gmask[gi]                = fill_reg;
    end
  endgenerate

  nv_nvdla_sdp_pack_oreg #(
    .W (OW + MAX_RATIO + 1)
  ) u_oreg (
    .clk       (nvdla_core_clk),
    .srst      (nvdla_core_rst),
    .load      (close),
    .load_data ({merged_data, merged_mask, merged_last}),
    .pvld      (out_pvld),
    .prdy      (out_prdy),
    .data      ({out_data, out_mask, out_last})
  );

  assign idle = (cnt_reg == '0) & !out_pvld;

  // The counter must stay below the latched ratio, and the fill mask must track it.
  a_cnt_range: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    (cnt_reg == '0) || (cnt_reg < ratio_reg));
  a_mask_empty: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    (cnt_reg != '0) || (gmask == '0));

endmodule

// File: tb/tb_nv_nvdla_sdp_core_gpack.sv
// Bench for the gather/pack block: directed boundary cases followed by a long
// randomized run, all checked against a queue-based reference model.
module tb_nv_nvdla_sdp_core_gpack;

  localparam int IW  = 8;
  localparam int MX  = 4;
  localparam int OW  = IW * MX;
  localparam int CW  = 3;
  localparam int WW  = OW + MX + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cfg_ratio;
  logic          inp_pvld;
  logic          inp_prdy;
  logic [IW-1:0] inp_data;
  logic          inp_last;
  logic          out_pvld;
  logic          out_prdy;
  logic [OW-1:0] out_data;
  logic [MX-1:0] out_mask;
  logic          out_last;
  logic          idle;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int close_cyc = -10;
  int words_seen = 0;

  logic [WW-1:0] exp_q[$];
  logic [IW-1:0] grp[$];
  int            model_r = 1;

  nv_nvdla_sdp_core_gpack #(
    .IW        (IW),
    .MAX_RATIO (MX)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_ratio      (cfg_ratio),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .inp_last       (inp_last),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_mask       (out_mask),
    .out_last       (out_last),
    .idle           (idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic int clamp_ref(input int c);
    if (c == 0) return 1;
    if (c > MX) return MX;
    return c;
  endfunction

  // Reference model: collect accepted beats into a group and emit the expected word on close.
  always @(negedge clk) begin
    logic [OW-1:0] w;
    logic [MX-1:0] m;
    logic          l;
    if (rst) begin
      grp.delete();
    end else begin
      if (out_prdy && inp_pvld) chk("no_gap_when_ready", inp_prdy, 1);
      if (inp_pvld && inp_prdy) begin
        if (grp.size() == 0) model_r = clamp_ref(int'(cfg_ratio));
        grp.push_back(inp_data);
        if (grp.size() == model_r || inp_last) begin
          w = '0;
          m = '0;
          for (int k = 0; k < grp.size(); k++) begin
            w = w | (OW'(grp[k]) << (IW * k));
            m[k] = 1'b1;
          end
          l = inp_last && (grp.size() != model_r);
          exp_q.push_back({w, m, l});
          $display("beat %02h closes group of %0d/%0d -> word %08h mask %04b last %0d",
                   inp_data, grp.size(), model_r, w, m, l);
          grp.delete();
          close_cyc = cyc;
        end
      end
    end
  end

  // Monitor: pop and compare on each output handshake; also check latency and stall stability.
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_word;
  always @(negedge clk) begin
    logic [WW-1:0] got;
    logic [WW-1:0] e;
    got = {out_data, out_mask, out_last};
    if (!rst) begin
      if (close_cyc == cyc - 1) chk("latency_pvld", out_pvld, 1);
      if (prev_hold) begin
        chk("stall_pvld", out_pvld, 1);
        chk("stall_word", got, prev_word);
      end
      if (out_pvld && out_prdy) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("word", got, e);
          $display("word out data=%08h mask=%04b last=%0d", out_data, out_mask, out_last);
        end
      end
    end
    prev_hold = !rst && out_pvld && !out_prdy;
    prev_word = got;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic l);
    int n;
    n = 0;
    inp_pvld = 1'b1;
    inp_data = d;
    inp_last = l;
    @(negedge clk);
    while (!inp_prdy && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("beat_timeout", 0, 1);
    tick();
    inp_pvld = 1'b0;
    inp_last = 1'b0;
  endtask

  initial begin
    int c0;
    bit done;
    rst = 1'b1;
    cfg_ratio = 3'd4;
    inp_pvld = 1'b0;
    inp_data = '0;
    inp_last = 1'b0;
    out_prdy = 1'b1;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("rst_inp_prdy", inp_prdy, 0);
    chk("rst_out_pvld", out_pvld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_out_last", out_last, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", idle, 1);
    tick();

    // Full group of 4
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    @(negedge clk);
    chk("t1_data", out_data, 32'h44332211);
    chk("t1_mask", out_mask, 4'b1111);
    chk("t1_last", out_last, 0);
    tick();

    // Short group closed by inp_last
    beat(8'hAA, 0); beat(8'hBB, 1);
    @(negedge clk);
    chk("t2_data", out_data, 32'h0000BBAA);
    chk("t2_mask", out_mask, 4'b0011);
    chk("t2_last", out_last, 1);
    tick();
    @(negedge clk);
    chk("t2_idle", idle, 1);
    tick();

    // R=2 with the output stalled
    cfg_ratio = 3'd2;
    out_prdy = 1'b0;
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0);
    inp_pvld = 1'b1;
    inp_data = 8'h04;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_prdy", inp_prdy, 0);
      chk("t3_held_word", out_data, 32'h00000201);
      tick();
    end
    out_prdy = 1'b1;
    @(negedge clk);
    chk("t3_release_prdy", inp_prdy, 1);
    tick();
    inp_pvld = 1'b0;
    @(negedge clk);
    chk("t3_word1_pvld", out_pvld, 1);
    chk("t3_word1_data", out_data, 32'h00000403);
    tick();

    // R=1 back-to-back, then saturating ratio, then mid-group ratio change
    cfg_ratio = 3'd0;
    c0 = cyc;
    beat(8'h10, 0); beat(8'h11, 0); beat(8'h12, 0); beat(8'h13, 0);
    chk("t4_r1_cycles", cyc - c0, 4);
    @(negedge clk);
    chk("t4_r1_mask", out_mask, 4'b0001);
    chk("t4_r1_data", out_data, 32'h00000013);
    tick();
    cfg_ratio = 3'd7;
    beat(8'h21, 0); beat(8'h22, 0); beat(8'h23, 0); beat(8'h24, 0);
    @(negedge clk);
    chk("t4_sat_mask", out_mask, 4'b1111);
    chk("t4_sat_data", out_data, 32'h24232221);
    tick();
    cfg_ratio = 3'd4;
    beat(8'h31, 0);
    cfg_ratio = 3'd2;
    beat(8'h32, 0); beat(8'h33, 0);
    @(negedge clk);
    chk("t4_midchange_open", out_pvld, 0);
    tick();
    beat(8'h34, 0);
    @(negedge clk);
    chk("t4_midchange_mask", out_mask, 4'b1111);
    chk("t4_midchange_data", out_data, 32'h34333231);
    tick();

    // Reset in the middle of a group discards it
    cfg_ratio = 3'd4;
    beat(8'hE1, 0); beat(8'hE2, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_prdy", inp_prdy, 0);
    tick();
    @(negedge clk);
    chk("t5_rst_pvld", out_pvld, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle", idle, 1);
    chk("t5_no_word_pending", exp_q.size(), 0);
    tick();
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0); beat(8'h04, 0);
    @(negedge clk);
    chk("t5_data", out_data, 32'h04030201);
    chk("t5_mask", out_mask, 4'b1111);
    tick();

    // Randomized traffic
    done = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) tick();
          cfg_ratio = CW'($urandom_range(0, 7));
          beat(IW'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          tick();
          out_prdy = ($urandom_range(0, 3) != 0);
        end
      end
    join

    // Drain and make sure every expected word came out
    inp_pvld = 1'b0;
    out_prdy = 1'b1;
    repeat (5) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("partial_group_empty", grp.size() == 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
